ntt_arbiter: RTL and testbench

NTT_ARBITER -- requirements
Module: ntt_arbiter

---
 rtl/ntt_arbiter.sv | 98 +++++++++
 tb/tb_ntt_arbiter.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/ntt_arbiter.sv
// ntt_arbiter: round-robin arbiter sharing one ntt core among NUM_REQ requesters.
// A requester served once must drop its request for a cycle before it can win again.
module ntt_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 20000,
    localparam int IDW = $clog2(NUM_REQ)
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [NUM_REQ-1:0] req_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [IDW-1:0]     gnt_id_o,
    output logic [NUM_REQ-1:0] done_o,
    output logic [NUM_REQ-1:0] err_o,
    output logic               core_start_o,
    input  logic               core_done_i,
    output logic               busy_o,
    output logic [15:0]        cycles_o
);
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] RUN     = 2'd1;
    localparam logic [1:0] RELEASE = 2'd2;

    logic [1:0]         state;
    logic [15:0]        cnt;
    logic [NUM_REQ-1:0] mask;
    logic [NUM_REQ-1:0] elig;
    logic [IDW-1:0]     last_id;
    logic [IDW-1:0]     win;
    logic               found;
    logic               leave;

    always_comb begin
        elig  = req_i & ~mask;
        win   = last_id;
        found = 1'b0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            if (!found && elig[(int'(last_id) + i) % NUM_REQ]) begin
                win   = IDW'((int'(last_id) + i) % NUM_REQ);
                found = 1'b1;
            end
        end
    end

    assign leave = core_done_i || !req_i[gnt_id_o] || cnt == 16'(TIMEOUT - 1);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state        <= IDLE;
            cnt          <= '0;
            mask         <= '0;
            last_id      <= IDW'(NUM_REQ - 1);
            gnt_o        <= '0;
            gnt_id_o     <= '0;
            done_o       <= '0;
            err_o        <= '0;
            core_start_o <= 1'b0;
            busy_o       <= 1'b0;
            cycles_o     <= '0;
        end else begin
            done_o <= '0;
            err_o  <= '0;
            mask   <= mask & req_i;
            case (state)
                IDLE: if (found) begin
                    gnt_o        <= NUM_REQ'(1) << win;
                    gnt_id_o     <= win;
                    core_start_o <= 1'b1;
                    busy_o       <= 1'b1;
                    cnt          <= '0;
                    state        <= RUN;
                end
                RUN: begin
                    cnt <= cnt + 16'd1;
                    if (leave) begin
                        state        <= RELEASE;
                        gnt_o        <= '0;
                        core_start_o <= 1'b0;
                        last_id      <= gnt_id_o;
                        // a low request this cycle wins over the new mask bit
                        mask         <= (mask | gnt_o) & req_i;
                        if (core_done_i) begin
                            done_o   <= gnt_o;
                            cycles_o <= cnt;
                        end else if (req_i[gnt_id_o]) begin
                            err_o <= gnt_o;
                        end
                    end
                end
                RELEASE: if (!core_done_i) begin
                    state  <= IDLE;
                    busy_o <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ntt_arbiter.sv
// tb_ntt_arbiter: directed checks of grant order, masking, abort, timeout and reset.
module tb_ntt_arbiter;
    logic clk_i = 1'b0;
    logic rst_ni = 1'b1;
    logic [3:0] req, gnt, dn, er;
    logic [1:0] gid;
    logic start, cdone, busy;
    logic [15:0] cycles;
    logic [3:0] t_req, t_gnt, t_dn, t_er;
    logic [1:0] t_gid;
    logic t_start, t_cdone, t_busy;
    logic [15:0] t_cycles;
    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    ntt_arbiter #(.NUM_REQ(4)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req), .gnt_o(gnt), .gnt_id_o(gid),
        .done_o(dn), .err_o(er), .core_start_o(start), .core_done_i(cdone),
        .busy_o(busy), .cycles_o(cycles)
    );

    ntt_arbiter #(.NUM_REQ(4), .TIMEOUT(16)) dut_to (
        .clk_i(clk_i), .rst_ni(rst_ni), .req_i(t_req), .gnt_o(t_gnt), .gnt_id_o(t_gid),
        .done_o(t_dn), .err_o(t_er), .core_start_o(t_start), .core_done_i(t_cdone),
        .busy_o(t_busy), .cycles_o(t_cycles)
    );

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic serve(input int id);
        tick();
        chk("rr_gnt", gnt, 32'(4'b1 << id));
        chk("rr_gid", gid, 32'(id));
        cdone = 1'b1;
        tick();
        chk("rr_done", dn, 32'(4'b1 << id));
        cdone  = 1'b0;
        req[id] = 1'b0;
        tick();
        chk("rr_idle", busy, 0);
        req[id] = 1'b1;
    endtask

    initial begin
        req = '0; cdone = 1'b0; t_req = '0; t_cdone = 1'b0;
        #2 rst_ni = 1'b0;
        #1;
        chk("rst_gnt", gnt, 0);
        chk("rst_start", start, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cycles", cycles, 0);
        tick(); tick();
        rst_ni = 1'b1;
        // single requester, 300 RUN cycles before done
        req = 4'b0001;
        tick();
        chk("t1_gnt", gnt, 4'b0001);
        chk("t1_start", start, 1);
        chk("t1_busy", busy, 1);
        repeat (150) tick();
        chk("t1_hold", {gnt, 3'b0, start}, {4'b0001, 4'b0001});
        repeat (150) tick();
        cdone = 1'b1;
        tick();
        chk("t1_done", dn, 4'b0001);
        chk("t1_cycles", cycles, 300);
        chk("t1_start_off", start, 0);
        chk("t1_gnt_off", gnt, 0);
        cdone = 1'b0; req = '0;
        tick();
        chk("t1_done_pulse", dn, 0);
        chk("t1_idle", busy, 0);
        // round robin from a fresh reset
        rst_ni = 1'b0;
        tick();
        rst_ni = 1'b1;
        req = 4'b1111;
        serve(0); serve(1); serve(2); serve(3); serve(0);
        req = '0;
        tick();
        // requester 2 keeps its request high after being served
        req = 4'b0100;
        tick();
        chk("t3_gnt", gnt, 4'b0100);
        cdone = 1'b1;
        tick();
        chk("t3_done", dn, 4'b0100);
        cdone = 1'b0;
        tick();
        tick();
        chk("t3_masked", gnt, 0);
        chk("t3_masked_busy", busy, 0);
        tick();
        chk("t3_masked2", gnt, 0);
        req[2] = 1'b0;
        tick();
        req[2] = 1'b1;
        tick();
        chk("t3_regrant", gnt, 4'b0100);
        repeat (7) tick();
        cdone = 1'b1;
        tick();
        chk("t3_cycles", cycles, 7);
        cdone = 1'b0; req = '0;
        tick();
        // abort by requester 1 at RUN cycle 5
        req = 4'b0010;
        tick();
        chk("t4_gnt", gnt, 4'b0010);
        chk("t4_gid", gid, 1);
        repeat (4) tick();
        req = '0;
        tick();
        chk("t4_start", start, 0);
        chk("t4_no_pulse", {dn, er}, 0);
        chk("t4_cycles", cycles, 7);
        chk("t4_release", busy, 1);
        cdone = 1'b1;
        tick();
        chk("t4_hold_release", busy, 1);
        chk("t4_no_done", dn, 0);
        cdone = 1'b0;
        tick();
        chk("t4_idle", busy, 0);
        // timeout on the TIMEOUT=16 instance
        t_req = 4'b0001;
        tick();
        chk("t5_start", t_start, 1);
        repeat (15) tick();
        chk("t5_pre_err", {t_er, 3'b0, t_start}, {4'b0000, 4'b0001});
        tick();
        chk("t5_err", t_er, 4'b0001);
        chk("t5_start_off", t_start, 0);
        chk("t5_cycles", t_cycles, 0);
        chk("t5_no_done", t_dn, 0);
        tick();
        chk("t5_err_pulse", t_er, 0);
        chk("t5_idle", t_busy, 0);
        t_req = '0;
        // asynchronous reset mid-RUN
        req = 4'b0001;
        tick();
        chk("t6_gnt", gnt, 4'b0001);
        repeat (3) tick();
        rst_ni = 1'b0;
        #1;
        chk("t6_start", start, 0);
        chk("t6_gnt_rst", gnt, 0);
        chk("t6_busy", busy, 0);
        chk("t6_cycles", cycles, 0);
        chk("t6_pulses", {dn, er}, 0);
        tick(); tick();
        rst_ni = 1'b1;
        tick();
        chk("t6_regrant", gnt, 4'b0001);
        chk("t6_restart", start, 1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
